// File: rtl/home_sequencer_if.sv
// Bus bundle between a controller and the homing sequencer.
//
// Request/acknowledge semantics: start is a one-cycle request that is
// accepted only when the sequencer is idle (busy=0) and abort is low; the
// acceptance is visible as busy=1 from the following cycle. While busy=1 any
// further start is dropped. done is a one-cycle completion pulse; fault is a
// sticky error flag cleared by the next accepted start. abort is a level that
// forces the sequencer back to idle on the next cycle.
interface home_sequencer_if;
  logic       start;
  logic       abort;
  logic       x_limit;
  logic       y_limit;
  logic       z_limit;
  logic [2:0] step;
  logic [2:0] dir;
  logic [2:0] enable_n;
  logic       busy;
  logic       done;
  logic       fault;
  logic [2:0] homed;

  // Controller / environment side
  modport master (
    output start, abort, x_limit, y_limit, z_limit,
    input  step, dir, enable_n, busy, done, fault, homed
  );

  // Sequencer side
  modport slave (
    input  start, abort, x_limit, y_limit, z_limit,
    output step, dir, enable_n, busy, done, fault, homed
  );
endinterface

// File: rtl/home_sequencer.sv
// Three-axis homing sequencer for A4988-style stepper drivers.
// Homes Z, then X, then Y: seek toward the limit switch, back off a fixed
// number of steps, settle, move to the next axis. Bit order everywhere is
// bit0 = X, bit1 = Y, bit2 = Z.
module home_sequencer #(
  parameter int STEP_HALF     = 64,
  parameter int MAX_STEPS     = 4096,
  parameter int BACKOFF_STEPS = 16,
  parameter int SETTLE        = 256
) (
  input  logic             clk,
  input  logic             rst,
  home_sequencer_if.slave  bus,
  output logic [2:0]       state_o
);

  localparam int CNT_MAX = (MAX_STEPS > BACKOFF_STEPS) ? MAX_STEPS : BACKOFF_STEPS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int HALF_W  = $clog2(STEP_HALF + 1);
  localparam int SET_W   = $clog2(SETTLE + 1);

  localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(STEP_HALF - 1);
  localparam logic [CNT_W-1:0]  SEEK_LIMIT = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0]  BACK_LIMIT = CNT_W'(BACKOFF_STEPS);
  localparam logic [SET_W-1:0]  SET_LAST   = SET_W'(SETTLE - 1);

  // Axis pointer values, in homing order
  localparam logic [1:0] AX_Z = 2'd0;
  localparam logic [1:0] AX_X = 2'd1;
  localparam logic [1:0] AX_Y = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEEK    = 3'd1,
    ST_BACKOFF = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_DONE    = 3'd4,
    ST_FAULT   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         axis_q, axis_d;
  logic [HALF_W-1:0]  half_q, half_d;
  logic               hi_q, hi_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [2:0]         homed_q, homed_d;
  logic               fault_q, fault_d;
  logic [2:0]         lim_meta_q, lim_s_q;

  logic [2:0]         axis_oh;
  logic               lim_act;
  logic               half_end;

  // Map the axis pointer onto the X/Y/Z pin bit.
  function automatic logic [2:0] axis_mask(input logic [1:0] a);
    case (a)
      AX_Z:    axis_mask = 3'b100;
      AX_X:    axis_mask = 3'b001;
      AX_Y:    axis_mask = 3'b010;
      default: axis_mask = 3'b000;
    endcase
  endfunction

  assign axis_oh  = axis_mask(axis_q);
  assign lim_act  = |(lim_s_q & axis_oh);
  assign half_end = (half_q == HALF_LAST);
  assign state_o  = state_q;

  // Two-flop synchronizers for the raw limit buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      lim_meta_q <= '0;
      lim_s_q    <= '0;
    end else begin
      lim_meta_q <= {bus.z_limit, bus.y_limit, bus.x_limit};
      lim_s_q    <= lim_meta_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      axis_q   <= AX_Z;
      half_q   <= '0;
      hi_q     <= 1'b0;
      cnt_q    <= '0;
      settle_q <= '0;
      homed_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      axis_q   <= axis_d;
      half_q   <= half_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      homed_q  <= homed_d;
      fault_q  <= fault_d;
    end
  end

  // Next-state logic. A motion state starts with one low half period so dir
  // is stable before the first rising edge; every later decision is taken at
  // the end of a low half, so a limit never cuts a period short.
  always_comb begin
    state_d  = state_q;
    axis_d   = axis_q;
    half_d   = half_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    homed_d  = homed_q;
    fault_d  = fault_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = ST_SEEK;
          axis_d  = AX_Z;
          homed_d = '0;
          fault_d = 1'b0;
          half_d  = '0;
          hi_d    = 1'b0;
          cnt_d   = '0;
        end
      end

      ST_SEEK: begin
        if (half_end) begin
          half_d = '0;
          if (hi_q) begin
            hi_d = 1'b0;
          end else if (lim_act) begin
            state_d = ST_BACKOFF;
            cnt_d   = '0;
          end else if (cnt_q == SEEK_LIMIT) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else begin
            hi_d  = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end

      ST_BACKOFF: begin
        if (half_end) begin
          half_d = '0;
          if (hi_q) begin
            hi_d = 1'b0;
          end else if (cnt_q == BACK_LIMIT) begin
            if (lim_act) begin
              state_d = ST_FAULT;
              fault_d = 1'b1;
            end else begin
              homed_d  = homed_q | axis_oh;
              state_d  = ST_SETTLE;
              settle_d = '0;
            end
          end else begin
            hi_d  = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end

      ST_SETTLE: begin
        if (settle_q == SET_LAST) begin
          if (axis_q == AX_Y) begin
            state_d = ST_DONE;
          end else begin
            axis_d  = axis_q + 2'd1;
            state_d = ST_SEEK;
            half_d  = '0;
            hi_d    = 1'b0;
            cnt_d   = '0;
          end
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Abort wins over everything except reset; earned flags are kept.
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      half_d   = '0;
      hi_d     = 1'b0;
      cnt_d    = '0;
      settle_d = '0;
      homed_d  = homed_q;
      fault_d  = fault_q;
    end
  end

  // Output decode: only the moving axis is enabled and stepped.
  always_comb begin
    bus.step     = 3'b000;
    bus.dir      = 3'b000;
    bus.enable_n = 3'b111;
    bus.busy     = (state_q != ST_IDLE);
    bus.done     = (state_q == ST_DONE);
    bus.fault    = fault_q;
    bus.homed    = homed_q;
    case (state_q)
      ST_SEEK: begin
        bus.enable_n = ~axis_oh;
        bus.dir      = axis_oh;
        bus.step     = hi_q ? axis_oh : 3'b000;
      end
      ST_BACKOFF: begin
        bus.enable_n = ~axis_oh;
        bus.step     = hi_q ? axis_oh : 3'b000;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/home_sequencer.md
HOME_SEQUENCER -- requirements
Module: home_sequencer

Interface
REQ-001 Parameter STEP_HALF, default 64: clk cycles per half step period (step high time = low time = STEP_HALF).
REQ-002 Parameter MAX_STEPS, default 4096: seek step budget per axis before fault.
REQ-003 Parameter BACKOFF_STEPS, default 16: steps driven away from the switch after contact.
REQ-004 Parameter SETTLE, default 256: idle clk cycles between axes.
REQ-005 clk  in  1  single clock for all logic; reset is synchronous and active-high.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  one-cycle request to begin homing; ignored while busy.
REQ-008 abort  in  1  level; cancels homing.
REQ-009 x_limit, y_limit, z_limit  in  1 each  raw limit buttons, 1 = pressed, asynchronous.
REQ-010 step  out  3  STEP pins, bit0 = X, bit1 = Y, bit2 = Z.
REQ-011 dir  out  3  DIR pins, 1 = toward the switch, 0 = away.
REQ-012 enable_n  out  3  A4988 ENABLE, active low.
REQ-013 busy  out  1  high from the first cycle after an accepted start until IDLE is re-entered.
REQ-014 done  out  1  one-cycle pulse on successful completion.
REQ-015 fault  out  1  sticky error flag.
REQ-016 homed  out  3  per-axis homed flags, same bit order as step.

Function
REQ-017 Each limit input SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (lim_s).
REQ-018 States: IDLE, SEEK, BACKOFF, SETTLE, DONE, FAULT; the axis pointer orders Z, then X, then Y.
REQ-019 In IDLE, start=1 SHALL clear homed and fault, select Z, and enter SEEK on the next cycle.
REQ-020 Only the active axis has enable_n=0; the other axes stay at enable_n=1 with step=0.
REQ-021 Step period: step=1 for STEP_HALF cycles, then step=0 for STEP_HALF cycles; the step counter increments on each rising edge of step.
REQ-022 dir SHALL be valid at least STEP_HALF cycles before any step rising edge, and dir changes only while step=0.
REQ-023 SEEK: dir=1; before each new period, lim_s=1 -> BACKOFF with step count cleared; otherwise, count==MAX_STEPS -> FAULT.
REQ-024 A limit seen during a period SHALL NOT truncate that period.
REQ-025 BACKOFF: dir=0; after BACKOFF_STEPS complete periods, lim_s=1 -> FAULT, otherwise set the homed bit for the axis and go to SETTLE.
REQ-026 SETTLE: all step=0 for SETTLE cycles, then advance to the next axis in SEEK; after Y, go to DONE.
REQ-027 DONE: pulse done for one cycle, then IDLE; homed=3'b111 is held until the next accepted start.
REQ-028 FAULT: fault=1, all enable_n=1, step=0, then IDLE; homed keeps the bits already earned.
REQ-029 abort=1 in any non-IDLE state: next cycle IDLE, step=0, enable_n=3'b111, busy=0, no done pulse, fault unchanged.
REQ-030 If abort and start are both high in IDLE, abort wins and start is ignored.
REQ-031 A limit already pressed at SEEK entry SHALL cause 0 seek steps and go straight to BACKOFF.
REQ-032 Counters SHALL be sized to hold MAX_STEPS, SETTLE and STEP_HALF without wrap-around.

Reset
REQ-033 With rst=1 at a clk edge: state=IDLE, step=3'b000, dir=3'b000, enable_n=3'b111, busy=0, done=0, fault=0, homed=3'b000, counters=0, synchronizers=0.
REQ-034 Reset mid-motion SHALL take effect on the next edge, drop step to 0 at once, and produce no done pulse.

Verification (STEP_HALF=2, MAX_STEPS=8, BACKOFF_STEPS=2, SETTLE=4)
REQ-035 Normal run: start; each limit asserts after 3 Z steps, 5 X steps and 1 Y step respectively -> rising-edge counts toward/away are Z 3/2, X 5/2, Y 1/2; step period 4 cycles; done pulses once; homed=3'b111.
REQ-036 Timeout: x_limit never asserts -> exactly 8 X steps, then fault=1, enable_n=3'b111, homed=3'b100, busy=0.
REQ-037 Stuck switch: z_limit held 1 from start -> 0 Z seek steps, 2 backoff steps, then fault=1 and homed=3'b000.
REQ-038 Abort during X SEEK -> next cycle step=0, enable_n=3'b111, busy=0, no done pulse; a fresh start then homes Z first.
REQ-039 Sync reset at an arbitrary cycle mid-BACKOFF -> all outputs equal their REQ-033 values on the following cycle.
REQ-040 start pulsed while busy, and start+abort together in IDLE -> both ignored, and the step trace is unchanged.
